rv32_regfile_alu_unit: RTL and testbench
========================================

Name: rv32_regfile_alu_unit

Overview:
RV32I execution datapath slice used by the multicycle core: a 32x32 integer register file, an ALU-control decoder and a combinational 32-bit ALU. The core supplies register indices, a write port, an instruction format code, funct3/funct7 and two ALU operands. The unit returns two register read values, the decoded ALU control and the ALU result.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
NREGS, 32, number of architectural registers; index width is 5.

Ports:
clk  input  1  clock, rising edge
resetn  input  1  reset; synchronous, active-low
rs1  input  5  read address port 1
rs2  input  5  read address port 2
w  input  5  write address
wdata  input  32  write data
we  input  1  register write enable
rdata1  output  32  value of register rs1
rdata2  output  32  value of register rs2
fmt  input  4  format code: R=0, I=1, IL(load)=2, IE(env)=3, S=4, B=5, J=6, JI(jalr)=7, U=8, UP(auipc)=9
funct3  input  3  instruction funct3
funct7  input  7  instruction funct7
alu_a  input  32  ALU operand A
alu_b  input  32  ALU operand B
alu_ctrl  output  4  decoded ALU operation
alu_result  output  32  ALU result

Behaviour:
Register file
- 32 registers of 32 bits; x0 always reads 0.
- Writes to x0 are ignored.
- Write happens on rising clk when resetn=1 and we=1 and w!=0.
- Reads are combinational/asynchronous.
- Without the bypass option, a read of the register being written in the same cycle returns the old value; the new value is visible after the edge.
- Reset: on a rising clk with resetn=0, all registers clear to 0. Reset takes priority over a simultaneous write.
- Reset asserted mid-operation discards any pending write in that cycle.

ALU decoder (combinational)
- Encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- fmt=R, by funct3: 0 gives SUB if funct7[5]=1, else ADD; 1 SLL; 2 SLT; 3 SLTU; 4 XOR; 5 gives SRA if funct7[5]=1, else SRL; 6 OR; 7 AND.
- fmt=I: same mapping, except funct3=0 is always ADD (no SUBI). funct3=5 still uses funct7[5] to select SRA vs SRL.
- All other fmt values (2–9, including B, used for target PC) give ADD.
- fmt 10–15 give ADD.

ALU (combinational, zero latency; clk is not used)
- ADD: a+b, modulo 2^32.
- SUB: a−b, modulo 2^32.
- SLL/SRL/SRA: shift amount is alu_b[4:0]; SRA replicates a[31].
- SLT: signed compare, result 1 or 0.
- SLTU: unsigned compare, result 1 or 0.
- XOR, OR, AND: bitwise.
- Undefined codes 10–15 produce 0.
- alu_result depends only on alu_a, alu_b and alu_ctrl; it is not affected by reset.
- Overflow is silently wrapped; there are no flags.

Optional Feature:
RF_BYPASS_EN
- Defined: if we=1, w!=0 and rsN==w in the same cycle, rdataN returns wdata combinationally (write-first forwarding). x0 still reads 0. Forwarding is suppressed while resetn=0.
- Not defined: pure asynchronous read of stored contents (old value), as above.

Test Plan:
- Reset and x0: hold resetn=0 for 1 clk, then read x1..x31 -> all 0. Write x0=0xDEADBEEF with we=1 -> rdata1 for rs1=0 reads 0.
- Write/read and same-cycle read: write x5=0x12345678 -> after the edge rs1=5 gives 0x12345678. During the write cycle, rdata1=old value (0), or 0x12345678 with RF_BYPASS_EN. Also confirm we=0 leaves the register unchanged.
- R-type decode/ALU:
  - fmt=0, funct3=0, funct7=0x20, a=5, b=7 -> alu_ctrl=1, result=0xFFFFFFFE.
  - funct3=5, funct7=0x20, a=0x80000000, b=4 -> 0xF8000000.
  - funct7=0 -> 0x08000000.
- Compares: a=0xFFFFFFFF, b=1 -> SLT=1, SLTU=0. AND/OR/XOR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
- I-type with funct3=0 and funct7=0x20 -> ADD (alu_ctrl=0). fmt=2,4,5,6,7,8,9 with any funct3 -> alu_ctrl=0. Shift with b=0x00000021 -> shift by 1.
- Reset mid-write: resetn=0 together with we=1, w=3, wdata=0xAA -> x3 reads 0 afterwards. The following write with resetn=1 takes effect.

Source files
------------

// File: rtl/rv32_regfile_alu_unit.sv
// rv32_regfile_alu_unit
//   RV32I execution datapath slice: 32x32 integer register file, ALU-control
//   decoder and combinational 32-bit ALU.
//
// Ports:
//   clk, resetn            clock (rising edge), synchronous active-low reset
//   rs1, rs2 -> rdata1/2   asynchronous register reads (x0 reads 0)
//   w, wdata, we           register write port (writes to x0 ignored)
//   fmt, funct3, funct7    instruction format code and function fields
//   alu_ctrl               decoded ALU operation
//   alu_a, alu_b           ALU operands
//   alu_result             ALU result (combinational, independent of reset)
//
// Optional feature macro: RF_BYPASS_EN
//   Defined: a read of the register being written in the same cycle returns
//   wdata (write-first forwarding), suppressed while resetn=0.
//   Undefined: reads return stored contents only.

module rv32_regfile_alu_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      w,
  input  logic [XLEN-1:0] wdata,
  input  logic            we,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic [3:0]      fmt,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_result
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [3:0] FMT_R = 4'd0;
  localparam logic [3:0] FMT_I = 4'd1;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = resetn && we && (w != '0);

  always_comb begin
    regs_d = regs_q;
    if (!resetn) begin
      regs_d = '{default: '0};
    end else if (wr_en) begin
      regs_d[w] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

`ifdef RF_BYPASS_EN
  // wr_en already excludes x0 and reset, so forwarding never overrides x0.
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : regs_q[rs1];
    rdata2 = (rs2 == '0) ? '0 : regs_q[rs2];
    if (wr_en && (rs1 == w)) rdata1 = wdata;
    if (wr_en && (rs2 == w)) rdata2 = wdata;
  end
`else
  always_comb begin
    rdata1 = (rs1 == '0) ? '0 : regs_q[rs1];
    rdata2 = (rs2 == '0) ? '0 : regs_q[rs2];
  end
`endif

  // ---------------------------------------------------------------------------
  // ALU-control decoder
  // ---------------------------------------------------------------------------
  alu_op_e op;
  logic    unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    op = ALU_ADD;
    if (fmt == FMT_R || fmt == FMT_I) begin
      unique case (funct3)
        3'd0: op = (fmt == FMT_R && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'd1: op = ALU_SLL;
        3'd2: op = ALU_SLT;
        3'd3: op = ALU_SLTU;
        3'd4: op = ALU_XOR;
        3'd5: op = funct7[5] ? ALU_SRA : ALU_SRL;
        3'd6: op = ALU_OR;
        3'd7: op = ALU_AND;
      endcase
    end
  end

  assign alu_ctrl = op;

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [4:0] shamt;

  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: tb/tb_rv32_regfile_alu_unit.sv
module tb_rv32_regfile_alu_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs1, rs2, w;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata1, rdata2;
  logic [3:0]  fmt;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_rf [32];

  always #5 clk = ~clk;

  rv32_regfile_alu_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .resetn(resetn),
    .rs1(rs1), .rs2(rs2), .w(w), .wdata(wdata), .we(we),
    .rdata1(rdata1), .rdata2(rdata2),
    .fmt(fmt), .funct3(funct3), .funct7(funct7),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Clock edge: registers update, model follows the architectural rules.
  task automatic tick();
    @(posedge clk);
    if (!resetn) begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    end else if (we && w != 5'd0) begin
      model_rf[w] = wdata;
    end
    #1;
  endtask

  // Expected read value of register r in the current (pre-edge) cycle.
  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (resetn && we && w != 5'd0 && r == w) return wdata;
`endif
    return model_rf[r];
  endfunction

  // Decoder reference from a per-funct3 operation table.
  function automatic logic [3:0] ref_ctrl(input logic [3:0] f, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (f > 4'd1) return 4'd0;
    if (f3 == 3'd0 && f == 4'd0 && f7[5]) return 4'd1;
    if (f3 == 3'd5 && f7[5]) return 4'd7;
    return base[f3];
  endfunction

  // ALU reference computed with wide integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, r;
    int sh;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    sh = int'(b % 32);
    case (c)
      4'd0: r = ua + ub;
      4'd1: r = ua - ub;
      4'd2: r = ua * (64'sd1 << sh);
      4'd3: r = (sa < sb) ? 1 : 0;
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = ua ^ ub;
      4'd6: r = ua / (64'sd1 << sh);
      4'd7: r = sa >>> sh;
      4'd8: r = ua | ub;
      4'd9: r = ua & ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic alu_step(input string tag, input logic [3:0] f, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] exp_ctrl, input logic [31:0] exp_res);
    fmt = f; funct3 = f3; funct7 = f7; alu_a = a; alu_b = b;
    #1;
    check({tag, "_ctrl"}, {28'h0, alu_ctrl}, {28'h0, exp_ctrl});
    check({tag, "_res"}, alu_result, exp_res);
  endtask

  initial begin
    logic [3:0] exp_c;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'hx;
    resetn = 1'b0; we = 1'b0; w = '0; wdata = '0; rs1 = '0; rs2 = '0;
    fmt = '0; funct3 = '0; funct7 = '0; alu_a = '0; alu_b = '0;
    #2;

    // Reset for one clock, then all registers read 0.
    tick();
    resetn = 1'b1;
    for (int i = 1; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i + 1);
      #1;
      check("reset_rd1", rdata1, 32'h0);
      check("reset_rd2", rdata2, 32'h0);
    end

    // x0 ignores writes.
    we = 1'b1; w = 5'd0; wdata = 32'hDEADBEEF; rs1 = 5'd0;
    tick();
    we = 1'b0;
    #1;
    check("x0_read", rdata1, 32'h0);

    // Write x5 and observe same-cycle / next-cycle visibility.
    we = 1'b1; w = 5'd5; wdata = 32'h12345678; rs1 = 5'd5; rs2 = 5'd5;
    #1;
`ifdef RF_BYPASS_EN
    check("samecyc_rd1", rdata1, 32'h12345678);
`else
    check("samecyc_rd1", rdata1, 32'h0);
`endif
    tick();
    we = 1'b0;
    #1;
    check("x5_after", rdata1, 32'h12345678);
    wdata = 32'hFFFF0000;
    tick();
    #1;
    check("we0_keep", rdata2, 32'h12345678);

    // Directed decode/ALU cases.
    alu_step("r_sub",    4'd0, 3'd0, 7'h20, 32'd5, 32'd7, 4'd1, 32'hFFFFFFFE);
    alu_step("r_sra",    4'd0, 3'd5, 7'h20, 32'h80000000, 32'd4, 4'd7, 32'hF8000000);
    alu_step("r_srl",    4'd0, 3'd5, 7'h00, 32'h80000000, 32'd4, 4'd6, 32'h08000000);
    alu_step("r_slt",    4'd0, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 4'd3, 32'd1);
    alu_step("r_sltu",   4'd0, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 4'd4, 32'd0);
    alu_step("r_and",    4'd0, 3'd7, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd9, 32'h00F000F0);
    alu_step("r_or",     4'd0, 3'd6, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd8, 32'hFFF0FFF0);
    alu_step("r_xor",    4'd0, 3'd4, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd5, 32'hFF00FF00);
    alu_step("i_nosub",  4'd1, 3'd0, 7'h20, 32'd5, 32'd7, 4'd0, 32'd12);
    alu_step("i_sll_wr", 4'd1, 3'd1, 7'h00, 32'd1, 32'h00000021, 4'd2, 32'd2);
    alu_step("i_srai",   4'd1, 3'd5, 7'h20, 32'h80000000, 32'd1, 4'd7, 32'hC0000000);
    for (int f = 2; f < 16; f++) begin
      alu_step("other_fmt", 4'(f), 3'(f), 7'h20, 32'hFFFFFFFF, 32'd3, 4'd0, 32'd2);
    end

    // Reset asserted together with a write discards the write.
    resetn = 1'b0; we = 1'b1; w = 5'd3; wdata = 32'hAA; rs1 = 5'd3; rs2 = 5'd5;
`ifdef RF_BYPASS_EN
    #1;
    check("rst_nofwd", rdata1, 32'h0);
`endif
    tick();
    resetn = 1'b1; we = 1'b0;
    #1;
    check("rst_wr_x3", rdata1, 32'h0);
    check("rst_clr_x5", rdata2, 32'h0);
    we = 1'b1; wdata = 32'h55;
    tick();
    we = 1'b0;
    #1;
    check("post_rst_wr", rdata1, 32'h55);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      resetn = ($urandom_range(0, 19) != 0);
      we     = 1'($urandom_range(0, 1));
      w      = 5'($urandom);
      wdata  = $urandom;
      rs1    = ($urandom_range(0, 3) == 0) ? w : 5'($urandom);
      rs2    = 5'($urandom);
      fmt    = 4'($urandom);
      if ($urandom_range(0, 1) == 1) fmt = 4'($urandom_range(0, 1));
      funct3 = 3'($urandom);
      funct7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom);
      alu_a  = $urandom;
      alu_b  = $urandom;
      #1;
      exp_c = ref_ctrl(fmt, funct3, funct7);
      check("rnd_rd1", rdata1, ref_read(rs1));
      check("rnd_rd2", rdata2, ref_read(rs2));
      check("rnd_ctrl", {28'h0, alu_ctrl}, {28'h0, exp_c});
      check("rnd_alu", alu_result, ref_alu(exp_c, alu_a, alu_b));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
